// File: rtl/io_channel_fifo.sv
// io_channel_fifo: buffered input/output channel pair for the zero machine.
// The input FIFO is filled from an external valid/ready stream and drained by the
// in instruction through a registered request/acknowledge port. The output FIFO is
// filled by the out instruction and drained by an external valid/ready consumer.
// When the output FIFO is full, OUT_WRAP selects between overwriting the oldest
// word and dropping the new one.

module io_channel_fifo #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned DEPTH    = 8,
    parameter bit          OUT_WRAP = 1'b1,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    // external producer -> input FIFO
    input  logic             i_s_in_valid,
    output logic             o_s_in_ready,
    input  logic [WIDTH-1:0] i_s_in_data,
    // machine side of the input FIFO
    output logic [CW-1:0]    o_in_size,
    input  logic             i_in_req,
    output logic [WIDTH-1:0] o_in_data,
    output logic             o_in_ack,
    // machine side of the output FIFO
    input  logic             i_out_req,
    input  logic [WIDTH-1:0] i_out_data,
    output logic             o_out_ack,
    // output FIFO -> external consumer
    output logic             o_m_out_valid,
    input  logic             i_m_out_ready,
    output logic [WIDTH-1:0] o_m_out_data,
    output logic [CW-1:0]    o_out_count,
    // sticky error flags
    output logic             o_underflow,
    output logic             o_overflow
);

    localparam int unsigned    PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    // ------------------------------------------------------------------
    // Input FIFO state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_in_mem [DEPTH];
    logic [PW-1:0]    r_in_head;
    logic [PW-1:0]    r_in_tail;
    logic [CW-1:0]    r_in_count;
    logic [WIDTH-1:0] r_in_data;
    logic             r_in_ack;
    logic             r_underflow;

    logic             w_in_push;
    logic             w_in_pop;
    logic             w_in_empty;
    logic [CW-1:0]    w_in_count_next;

    // ------------------------------------------------------------------
    // Output FIFO state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_out_mem [DEPTH];
    logic [PW-1:0]    r_out_head;
    logic [PW-1:0]    r_out_tail;
    logic [CW-1:0]    r_out_count;
    logic             r_out_ack;
    logic             r_overflow;

    logic             w_out_pop;
    logic             w_out_full;
    logic             w_out_store;
    logic             w_out_wrap;
    logic             w_out_reject;
    logic             w_out_write;
    logic             w_out_head_adv;
    logic [CW-1:0]    w_out_count_next;

    // Input FIFO handshake decode; ready depends on the registered count only.
    always_comb begin
        w_in_empty      = (r_in_count == '0);
        o_s_in_ready    = (r_in_count < FULL_CNT);
        w_in_push       = i_s_in_valid && o_s_in_ready;
        // A pop only sees words already held; a same-cycle push is not visible.
        w_in_pop        = i_in_req && !w_in_empty;
        w_in_count_next = r_in_count + CW'(w_in_push) - CW'(w_in_pop);
    end

    // Input FIFO pointers, count, pop result and underflow flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_in_head   <= '0;
            r_in_tail   <= '0;
            r_in_count  <= '0;
            r_in_data   <= '0;
            r_in_ack    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_in_count <= w_in_count_next;
            r_in_ack   <= w_in_pop;
            if (w_in_push) begin
                r_in_tail <= r_in_tail + PTR_ONE;
            end
            if (w_in_pop) begin
                r_in_head <= r_in_head + PTR_ONE;
            end
            if (i_in_req) begin
                // Empty pop returns zero with no acknowledge.
                r_in_data <= w_in_pop ? r_in_mem[r_in_head] : '0;
            end
            if (i_in_req && w_in_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Input FIFO storage; contents are not cleared by reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_in_push) begin
            r_in_mem[r_in_tail] <= i_s_in_data;
        end
    end

    // Output FIFO decode: normal store, wrap-overwrite, or rejected request.
    always_comb begin
        w_out_full       = (r_out_count == FULL_CNT);
        w_out_pop        = (r_out_count != '0) && i_m_out_ready;
        // A same-cycle pop frees a slot, so a full FIFO still accepts normally.
        w_out_store      = i_out_req && (!w_out_full || w_out_pop);
        w_out_reject     = i_out_req && w_out_full && !w_out_pop;
        w_out_wrap       = w_out_reject && OUT_WRAP;
        w_out_write      = w_out_store || w_out_wrap;
        // Overwriting the oldest word drops it, so the head moves with the tail.
        w_out_head_adv   = w_out_pop || w_out_wrap;
        w_out_count_next = r_out_count + CW'(w_out_store) - CW'(w_out_pop);
    end

    // Output FIFO pointers, count, acknowledge and overflow flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_head  <= '0;
            r_out_tail  <= '0;
            r_out_count <= '0;
            r_out_ack   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_count <= w_out_count_next;
            r_out_ack   <= w_out_write;
            if (w_out_write) begin
                r_out_tail <= r_out_tail + PTR_ONE;
            end
            if (w_out_head_adv) begin
                r_out_head <= r_out_head + PTR_ONE;
            end
            if (w_out_reject) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output FIFO storage; contents are not cleared by reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_out_write) begin
            r_out_mem[r_out_tail] <= i_out_data;
        end
    end

    // Output port mapping; the output head is a fall-through read of storage.
    always_comb begin
        o_in_size     = r_in_count;
        o_in_data     = r_in_data;
        o_in_ack      = r_in_ack;
        o_underflow   = r_underflow;
        o_out_ack     = r_out_ack;
        o_overflow    = r_overflow;
        o_out_count   = r_out_count;
        o_m_out_valid = (r_out_count != '0);
        o_m_out_data  = r_out_mem[r_out_head];
    end

endmodule

// File: tb/tb_io_channel_fifo.sv
// Bench for io_channel_fifo: two instances (wrap and drop on full output) share
// one stimulus stream and are compared every cycle against a queue-based model.

module tb_io_channel_fifo;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             s_in_valid;
    logic [WIDTH-1:0] s_in_data;
    logic             in_req;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             m_out_ready;

    // wrap-mode instance outputs
    logic             w_s_in_ready, w_in_ack, w_out_ack, w_m_out_valid, w_underflow, w_overflow;
    logic [CW-1:0]    w_in_size, w_out_count;
    logic [WIDTH-1:0] w_in_data, w_m_out_data;
    // drop-mode instance outputs
    logic             d_s_in_ready, d_in_ack, d_out_ack, d_m_out_valid, d_underflow, d_overflow;
    logic [CW-1:0]    d_in_size, d_out_count;
    logic [WIDTH-1:0] d_in_data, d_m_out_data;

    always #5 clock = ~clock;

    io_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_WRAP(1'b1)) u_dut_wrap (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_s_in_valid  (s_in_valid),
        .o_s_in_ready  (w_s_in_ready),
        .i_s_in_data   (s_in_data),
        .o_in_size     (w_in_size),
        .i_in_req      (in_req),
        .o_in_data     (w_in_data),
        .o_in_ack      (w_in_ack),
        .i_out_req     (out_req),
        .i_out_data    (out_data),
        .o_out_ack     (w_out_ack),
        .o_m_out_valid (w_m_out_valid),
        .i_m_out_ready (m_out_ready),
        .o_m_out_data  (w_m_out_data),
        .o_out_count   (w_out_count),
        .o_underflow   (w_underflow),
        .o_overflow    (w_overflow)
    );

    io_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_WRAP(1'b0)) u_dut_drop (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_s_in_valid  (s_in_valid),
        .o_s_in_ready  (d_s_in_ready),
        .i_s_in_data   (s_in_data),
        .o_in_size     (d_in_size),
        .i_in_req      (in_req),
        .o_in_data     (d_in_data),
        .o_in_ack      (d_in_ack),
        .i_out_req     (out_req),
        .i_out_data    (out_data),
        .o_out_ack     (d_out_ack),
        .o_m_out_valid (d_m_out_valid),
        .i_m_out_ready (m_out_ready),
        .o_m_out_data  (d_m_out_data),
        .o_out_count   (d_out_count),
        .o_underflow   (d_underflow),
        .o_overflow    (d_overflow)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned in_q[$];
    int unsigned outq_w[$];
    int unsigned outq_d[$];
    bit          m_in_ack, m_uf, m_ack_w, m_ack_d, m_ovf_w, m_ovf_d, m_in_chk;
    int unsigned m_in_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        outq_w.delete();
        outq_d.delete();
        m_in_ack  = 1'b0;
        m_uf      = 1'b0;
        m_ack_w   = 1'b0;
        m_ack_d   = 1'b0;
        m_ovf_w   = 1'b0;
        m_ovf_d   = 1'b0;
        m_in_data = 0;
        m_in_chk  = 1'b1;
    endtask

    task automatic set_in(input bit v, input int unsigned d, input bit ir,
                          input bit orq, input int unsigned od, input bit rdy);
        s_in_valid  = v;
        s_in_data   = WIDTH'(d);
        in_req      = ir;
        out_req     = orq;
        out_data    = WIDTH'(od);
        m_out_ready = rdy;
    endtask

    // Compare all outputs with the model, advance the model, then clock once.
    task automatic cycle();
        bit push, pop, popo, full;
        check_eq("s_in_ready", 32'(w_s_in_ready), 32'(in_q.size() < DEPTH));
        check_eq("in_size", 32'(w_in_size), in_q.size());
        check_eq("in_size_drop", 32'(d_in_size), in_q.size());
        check_eq("in_ack", 32'(w_in_ack), 32'(m_in_ack));
        if (m_in_chk) check_eq("in_data", 32'(w_in_data), m_in_data);
        check_eq("underflow", 32'(w_underflow), 32'(m_uf));
        check_eq("out_count_wrap", 32'(w_out_count), outq_w.size());
        check_eq("out_valid_wrap", 32'(w_m_out_valid), 32'(outq_w.size() > 0));
        if (outq_w.size() > 0) check_eq("out_data_wrap", 32'(w_m_out_data), outq_w[0]);
        check_eq("out_ack_wrap", 32'(w_out_ack), 32'(m_ack_w));
        check_eq("overflow_wrap", 32'(w_overflow), 32'(m_ovf_w));
        check_eq("out_count_drop", 32'(d_out_count), outq_d.size());
        check_eq("out_valid_drop", 32'(d_m_out_valid), 32'(outq_d.size() > 0));
        if (outq_d.size() > 0) check_eq("out_data_drop", 32'(d_m_out_data), outq_d[0]);
        check_eq("out_ack_drop", 32'(d_out_ack), 32'(m_ack_d));
        check_eq("overflow_drop", 32'(d_overflow), 32'(m_ovf_d));

        if (reset) begin
            model_reset();
        end else begin
            // input channel: pop sees only words held before this edge
            push     = s_in_valid && (in_q.size() < DEPTH);
            pop      = in_req && (in_q.size() > 0);
            m_in_chk = in_req;
            m_in_ack = pop;
            if (in_req) m_in_data = pop ? in_q[0] : 0;
            if (in_req && !pop) m_uf = 1'b1;
            if (pop) void'(in_q.pop_front());
            if (push) in_q.push_back(int'(s_in_data));

            // output channel, wrap mode
            popo    = m_out_ready && (outq_w.size() > 0);
            full    = (outq_w.size() == DEPTH);
            m_ack_w = out_req;
            if (popo) void'(outq_w.pop_front());
            if (out_req) begin
                if (full && !popo) begin
                    m_ovf_w = 1'b1;
                    void'(outq_w.pop_front());
                end
                outq_w.push_back(int'(out_data));
            end

            // output channel, drop mode
            popo    = m_out_ready && (outq_d.size() > 0);
            full    = (outq_d.size() == DEPTH);
            m_ack_d = out_req && (!full || popo);
            if (popo) void'(outq_d.pop_front());
            if (out_req) begin
                if (full && !popo) m_ovf_d = 1'b1;
                else outq_d.push_back(int'(out_data));
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        cycle();
        reset = 1'b0;
        cycle();

        // basic order through both channels
        set_in(1, 33, 0, 0, 0, 0); cycle();
        set_in(1, 22, 0, 0, 0, 0); cycle();
        set_in(1, 11, 0, 0, 0, 0); cycle();
        set_in(0, 0, 1, 0, 0, 0);
        repeat (3) cycle();
        set_in(0, 0, 0, 1, 3, 0);  cycle();
        set_in(0, 0, 0, 1, 33, 0); cycle();
        set_in(0, 0, 0, 1, 2, 0);  cycle();
        set_in(0, 0, 0, 1, 22, 0); cycle();
        set_in(0, 0, 0, 1, 1, 0);  cycle();
        set_in(0, 0, 0, 1, 11, 0); cycle();
        set_in(0, 0, 0, 0, 0, 1);
        repeat (7) cycle();

        // fill input FIFO, pop/push overlap around full
        for (int i = 0; i < 9; i++) begin
            set_in(1, 100 + i, 0, 0, 0, 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1, 200 + i, 1, 0, 0, 0);
            cycle();
        end
        set_in(0, 0, 1, 0, 0, 0);
        repeat (10) cycle();

        // underflow is sticky
        set_in(0, 0, 1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // output full: wrap overwrites oldest, drop discards newest
        for (int i = 1; i <= 10; i++) begin
            set_in(0, 0, 0, 1, i, 0);
            cycle();
        end
        set_in(0, 0, 0, 1, 11, 1); cycle();
        set_in(0, 0, 0, 0, 0, 1);
        repeat (10) cycle();

        // reset mid-burst with both FIFOs half full
        for (int i = 0; i < 4; i++) begin
            set_in(1, 50 + i, 0, 1, 60 + i, 0);
            cycle();
        end
        reset = 1'b1;
        set_in(1, 70, 1, 1, 71, 1); cycle();
        reset = 1'b0;
        set_in(1, 5, 0, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0); cycle();
        set_in(0, 0, 1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0); cycle();
        check_eq("reset_then_pop5", 32'(w_in_data), 32'd5);

        // randomized traffic with varying pressure
        for (int i = 0; i < 3000; i++) begin
            int unsigned bias;
            bias = (i / 500) % 3;
            reset = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 3) > bias ? 1'b1 : 1'b0, $urandom_range(0, 4095),
                   $urandom_range(0, 3) < bias + 1 ? 1'b1 : 1'b0,
                   $urandom_range(0, 2) > 0 ? 1'b1 : 1'b0, $urandom_range(0, 4095),
                   $urandom_range(0, 3) < bias + 1 ? 1'b1 : 1'b0);
            cycle();
        end
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
